// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer owning HI/LO; computes on start, commits after a fixed busy window.
// Latency: MULT_CYCLES / DIV_CYCLES cycles of busy, HI/LO update on the edge busy falls; mthi/mtlo same edge.
// Backpressure: no handshake; stall holds the pipeline while an MDU instruction meets a busy unit.
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [31:0] res_hi, res_lo;
    logic        dz;

    logic        is_arith;
    logic        load;
    logic        commit;

    // Arithmetic results, all computed from the operands presented with start
    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, div_b, uq, ur, sq, sr, uq_u, ur_u;
    logic [31:0] calc_hi, calc_lo;
    logic        calc_dz;

    assign is_arith = (op[2] == 1'b0);
    assign busy     = (state == RUN);
    assign stall    = md_use & (busy | (start & is_arith));

    // Operand-level math; zero divisors are replaced by 1 so the divider never sees 0
    always_comb begin
        prod_s  = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
        prod_u  = {32'd0, rs_val} * {32'd0, rt_val};
        abs_a   = rs_val[31] ? (32'd0 - rs_val) : rs_val;
        abs_b   = rt_val[31] ? (32'd0 - rt_val) : rt_val;
        div_b   = (abs_b == 32'd0) ? 32'd1 : abs_b;
        uq      = abs_a / div_b;
        ur      = abs_a % div_b;
        sq      = (rs_val[31] ^ rt_val[31]) ? (32'd0 - uq) : uq;
        sr      = rs_val[31] ? (32'd0 - ur) : ur;
        uq_u    = rs_val / ((rt_val == 32'd0) ? 32'd1 : rt_val);
        ur_u    = rs_val % ((rt_val == 32'd0) ? 32'd1 : rt_val);
        calc_hi = 32'd0;
        calc_lo = 32'd0;
        calc_dz = 1'b0;
        case (op)
            OP_MULT:  begin calc_hi = prod_s[63:32]; calc_lo = prod_s[31:0]; end
            OP_MULTU: begin calc_hi = prod_u[63:32]; calc_lo = prod_u[31:0]; end
            OP_DIV:   begin calc_hi = sr;   calc_lo = sq;   calc_dz = (rt_val == 32'd0); end
            OP_DIVU:  begin calc_hi = ur_u; calc_lo = uq_u; calc_dz = (rt_val == 32'd0); end
            default:  begin calc_hi = 32'd0; calc_lo = 32'd0; calc_dz = 1'b0; end
        endcase
    end

    // Next-state: accept arithmetic only in IDLE, leave RUN on the last counted edge
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (start && is_arith) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == 4'd1) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Counter, result latches, HI/LO and the done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= 4'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            dz     <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            done   <= 1'b0;
        end else begin
            done <= commit;
            if (load) begin
                res_hi <= calc_hi;
                res_lo <= calc_lo;
                dz     <= calc_dz;
                cnt    <= (op[1] == 1'b0) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            end else if (state == RUN) begin
                cnt <= cnt - 4'd1;
            end
            if (commit && !dz) begin
                hi <= res_hi;
                lo <= res_lo;
            end
            // Moves to HI/LO only land while the unit is idle
            if (state == IDLE && start && op == OP_MTHI) hi <= rs_val;
            if (state == IDLE && start && op == OP_MTLO) lo <= rs_val;
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        md_use;
    logic        busy, done, stall;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .md_use(md_use),
        .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending result
    always @(negedge clk) begin
        if (!reset && done === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({hi, lo} !== e) begin
                    n_bad++;
                    $display("FAIL commit_hilo: got %h_%h expected %h_%h", hi, lo, e[63:32], e[31:0]);
                end
            end
        end
    end

    // Issue one arithmetic op; optionally hold md_use and inject a stray start at busy cycle inj
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int n,
                         input logic mdu, input int inj);
        int cyc;
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b; md_use = mdu;
        #1;
        if (mdu) check("stall_on_start", {31'd0, stall}, 32'd1);
        if (!((o == 3'd2 || o == 3'd3) && b == 32'd0)) begin
            m_hi = eh; m_lo = el;
        end
        exp_q.push_back({m_hi, m_lo});
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            if (mdu) check("stall_in_busy", {31'd0, stall}, 32'd1);
            if (cyc == inj) begin
                start = 1'b1; op = 3'd0; rs_val = 32'd3; rt_val = 32'd3;
            end
            @(negedge clk);
            start = 1'b0;
        end
        check("busy_cycles", cyc, n);
        if (mdu) check("stall_after_busy", {31'd0, stall}, 32'd0);
        md_use = 1'b0;
        @(negedge clk);
        #1;
        check("done_seen", exp_q.size(), 0);
        check("idle_after", {31'd0, busy}, 32'd0);
    endtask

    task automatic move(input logic [2:0] o, input logic [31:0] v);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = v;
        @(negedge clk);
        start = 1'b0;
        if (o == 3'd4) m_hi = v; else m_lo = v;
        check("move_hi", hi, m_hi);
        check("move_lo", lo, m_lo);
        check("move_no_busy", {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b1; op = 3'd0; rs_val = 32'd0; rt_val = 32'd0; md_use = 1'b1;
        #40;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd1);
        start = 1'b0; md_use = 1'b0;
        #5 reset = 1'b0;

        issue(3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5, 1'b0, 0);
        issue(3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 10, 1'b0, 0);
        issue(3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0, 0);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10, 1'b0, 0);
        move(3'd4, 32'h12345678);
        issue(3'd3, 32'd9, 32'd0, 32'd0, 32'd0, 10, 1'b0, 0);
        check("dz_hi", hi, 32'h12345678);
        check("dz_lo", lo, 32'h80000000);
        move(3'd5, 32'h0000AAAA);
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5, 1'b0, 2);
        issue(3'd0, 32'h00010000, 32'h00010000, 32'd1, 32'd0, 5, 1'b1, 0);
        issue(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1'b0, 0);

        // Reset in the middle of a div: everything clears at once, nothing commits later
        @(negedge clk);
        start = 1'b1; op = 3'd2; rs_val = 32'd50; rt_val = 32'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("no_late_hi", hi, 32'd0);
        check("no_late_lo", lo, 32'd0);
        issue(3'd0, 32'd6, 32'd7, 32'd0, 32'd42, 5, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multiply/divide unit sequencer for the pipelined MIPS core. It sits beside the E-stage ALU and accepts mult/multu/div/divu/mthi/mtlo requests from the pipeline. It models the fixed multi-cycle latency of the unit and owns the HI/LO architectural registers. It also drives the stall request the hazard logic uses to hold the pipeline while HI/LO are not ready.

## Interface
- MULT_CYCLES, 5, busy duration of mult/multu in cycles (≥1)
- DIV_CYCLES, 10, busy duration of div/divu in cycles (≥1)

Ports:
- clk  in  1  single clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  E-stage request valid this cycle
- op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6–7 no-op
- rs_val  in  32  operand A / mthi-mtlo source
- rt_val  in  32  operand B
- md_use  in  1  E-stage instruction is any MDU instruction (incl. mfhi/mflo)
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse after HI/LO commit of a mult/div
- stall  out  1  pipeline hold request
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, RUN. 4-bit down-counter `cnt`; result latches `res_hi`, `res_lo`; 1-bit `dz` (div by zero).
- IDLE, start=1, op∈{0..3}:
  - compute result from rs_val/rt_val into res_hi/res_lo
  - load cnt = MULT_CYCLES or DIV_CYCLES
  - go RUN
- IDLE, start=1, op=4/5: hi (resp. lo) ← rs_val at that edge; stay IDLE; busy stays 0.
- IDLE, op 6–7 or start=0: no effect.
- RUN:
  - cnt decrements each edge.
  - On the edge where cnt==1: commit res_hi→hi, res_lo→lo (skipped if dz), go IDLE, done←1.
- start while RUN (any op): ignored. The pipeline guarantees this does not occur, because stall is asserted.
- Arithmetic:
  - mult: signed 32×32→64, {hi,lo}.
  - multu: unsigned 32×32→64, {hi,lo}.
  - div: lo = quotient truncated toward zero; hi = remainder with sign of dividend. 0x80000000 / −1 → lo=0x80000000, hi=0.
  - divu: unsigned quotient→lo, remainder→hi.
  - rt_val==0 on div/divu: dz=1, full DIV_CYCLES busy, hi/lo unchanged.
- stall = md_use & (busy | (start & op∈{0..3})), combinational.
- Reset (any time, incl. mid-RUN): state IDLE, cnt=0, busy=0, done=0, hi=0, lo=0, res_*=0, dz=0; the in-flight op is discarded.

## Timing
- Reset values: busy=0, done=0, stall=md_use&start&op∈{0..3} (combinational), hi=0, lo=0.
- Let edge t0 be the edge that samples start=1 for mult/div with latency N:
  - busy=1 in the cycles after edges t0 … t0+N−1, i.e. exactly N cycles.
  - hi/lo change at edge t0+N.
  - busy falls at edge t0+N.
  - done=1 for the single cycle after edge t0+N.
- A new start may be sampled at edge t0+N+1 at the earliest, since busy is low in the cycle before it. Back-to-back ops therefore run with no dead cycle beyond that.
- mthi/mtlo: hi/lo update at the sampling edge; no busy, no done.
- hi/lo are registered outputs only; no bypass of res_* onto hi/lo.

## Test plan
- Reset 45 ns, then mult rs=0xFFFFFFFD (−3), rt=5 → busy high exactly 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFF1 at the falling edge of busy; done pulses once.
- divu rs=7, rt=2 → busy 10 cycles; lo=3, hi=1. Then div rs=0xFFFFFFF9 (−7), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Overflow and zero divisor:
  - div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - divu rs=9, rt=0 after mthi 0x12345678 → 10 busy cycles, done pulses, hi=0x12345678, lo unchanged.
- multu 0xFFFFFFFF×0xFFFFFFFF, with mtlo 0xAAAA and a second mult start issued in cycle 2 of busy:
  - second start ignored.
  - hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
- md_use=1 (mflo) in every busy cycle → stall=1 throughout busy, 0 the cycle busy drops. md_use=1 with start mult in IDLE → stall=1 the same cycle.
- Assert reset at cycle 3 of a div → busy, done, hi and lo go to 0 immediately (async). No commit occurs afterwards. The next mult completes normally.
